// File: rtl/bht_predictor_if.sv
// Lookup (IF) and update (EX) signal bundle for bht_predictor.
// The master modport is the pipeline side; the slave modport is the predictor.
interface bht_predictor_if;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_br_en;
    logic        bht_ready;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_pc, upd_br_en,
        input  pred_taken, bht_ready
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_pc, upd_br_en,
        output pred_taken, bht_ready
    );
endinterface

// File: rtl/bht_predictor.sv
// Branch history table of 2-bit saturating counters, swept to INIT_CTR after reset.
// Define BHT_GSHARE_EN to XOR a non-speculative global history into the index.
module bht_predictor #(
    parameter int         IDX_BITS = 6,
    parameter logic [1:0] INIT_CTR = 2'b01,
    parameter int         GHR_BITS = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    bht_predictor_if.slave bus
);

    localparam int ENTRIES = 1 << IDX_BITS;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          r_state;
    logic [IDX_BITS-1:0] r_sweep_idx;
    logic [1:0]          r_ctr [ENTRIES];

    logic                w_ready;
    logic                w_upd_en;
    logic [IDX_BITS-1:0] w_pred_idx;
    logic [IDX_BITS-1:0] w_upd_idx;
    logic [1:0]          w_ctr_cur;
    logic [1:0]          w_ctr_next;

    assign w_ready  = (r_state == ST_RUN);
    assign w_upd_en = w_ready & bus.upd_valid;

`ifdef BHT_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;
    logic [IDX_BITS-1:0] w_ghr_ext;

    assign w_ghr_ext  = IDX_BITS'(r_ghr);
    assign w_pred_idx = bus.pred_pc[IDX_BITS+1:2] ^ w_ghr_ext;
    assign w_upd_idx  = bus.upd_pc[IDX_BITS+1:2] ^ w_ghr_ext;

    // History only advances on accepted updates, so INIT leaves it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (w_upd_en) begin
            r_ghr <= {r_ghr[GHR_BITS-2:0], bus.upd_br_en};
        end
    end

    logic w_unused_pc;
    assign w_unused_pc = ^{bus.pred_pc[31:IDX_BITS+2], bus.pred_pc[1:0],
                           bus.upd_pc[31:IDX_BITS+2], bus.upd_pc[1:0]};
`else
    assign w_pred_idx = bus.pred_pc[IDX_BITS+1:2];
    assign w_upd_idx  = bus.upd_pc[IDX_BITS+1:2];

    logic w_unused_pc;
    assign w_unused_pc = ^{bus.pred_pc[31:IDX_BITS+2], bus.pred_pc[1:0],
                           bus.upd_pc[31:IDX_BITS+2], bus.upd_pc[1:0],
                           GHR_BITS[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_sweep_idx <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_sweep_idx <= r_sweep_idx + 1'b1;
                    if (r_sweep_idx == IDX_BITS'(ENTRIES - 1)) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign w_ctr_cur = r_ctr[w_upd_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (bus.upd_br_en) begin
            if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
        end
    end

    // NOTE: the table has no reset branch; the INIT sweep clears it, which keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_ctr[r_sweep_idx] <= INIT_CTR;
        end else if (w_upd_en) begin
            r_ctr[w_upd_idx] <= w_ctr_next;
        end
    end

    // Read is combinational and sees the pre-update value on a same-index update.
    assign bus.pred_taken = w_ready & bus.pred_valid & r_ctr[w_pred_idx][1];
    assign bus.bht_ready  = w_ready;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: a reference counter model feeds an expected-value
// queue at drive time; outputs are popped and checked at the falling edge.
module tb_bht_predictor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bht_predictor_if bus ();

    bht_predictor dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [1:0] m_ctr [64];
    logic       m_ready;
    int         m_sweep;
    logic [5:0] m_ghr;
    logic       exp_q [$];

    function automatic logic [5:0] m_idx(input logic [31:0] pc);
`ifdef BHT_GSHARE_EN
        return pc[7:2] ^ m_ghr;
`else
        return pc[7:2];
`endif
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_sweep = 0;
        m_ghr   = '0;
    endtask

    // Reference behaviour at a rising edge, using the inputs held during that cycle.
    task automatic model_edge(input logic uv, input logic [31:0] upc, input logic ubr);
        logic [5:0] idx;
        if (!rst_n) return;
        if (!m_ready) begin
            m_ctr[m_sweep] = 2'b01;
            m_sweep++;
            if (m_sweep == 64) m_ready = 1'b1;
        end else if (uv) begin
            idx = m_idx(upc);
            if (ubr) begin
                if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'b01;
            end else begin
                if (m_ctr[idx] != 2'b00) m_ctr[idx] = m_ctr[idx] - 2'b01;
            end
            m_ghr = {m_ghr[4:0], ubr};
        end
    endtask

    // One clock cycle: drive, push expectation, check at negedge, advance model at posedge.
    task automatic step(input string tag, input logic pv, input logic [31:0] ppc,
                        input logic uv, input logic [31:0] upc, input logic ubr);
        bus.pred_valid = pv;
        bus.pred_pc    = ppc;
        bus.upd_valid  = uv;
        bus.upd_pc     = upc;
        bus.upd_br_en  = ubr;
        exp_q.push_back(m_ready & pv & m_ctr[m_idx(ppc)][1]);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_pred scoreboard empty observed=%b", tag, bus.pred_taken);
        end else begin
            check({tag, "_pred"}, bus.pred_taken, exp_q.pop_front());
        end
        check({tag, "_ready"}, bus.bht_ready, m_ready);
        @(posedge clk);
        model_edge(uv, upc, ubr);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc);
        step(tag, 1'b1, pc, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input string tag, input logic [31:0] pc, input logic br);
        step(tag, 1'b0, 32'h0, 1'b1, pc, br);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        bus.pred_valid = 1'b1;
        bus.pred_pc    = 32'h104;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = 32'h0;
        bus.upd_br_en  = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        check("rst_ready", bus.bht_ready, 1'b0);
        check("rst_pred", bus.pred_taken, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: 64-cycle sweep with lookups held high
        for (int i = 0; i < 64; i++) look("t1_sweep", 32'h104);
        look("t1_ready", 32'h104);

        // 2: two taken updates at 0x104
        upd("t2_u1", 32'h104, 1'b1);
        look("t2_l1", 32'h104);
        upd("t2_u2", 32'h104, 1'b1);
        look("t2_l2", 32'h104);
        step("t2_pv0", 1'b0, 32'h104, 1'b0, 32'h0, 1'b0);

        // 3: saturate high at 0x108 then walk down
        for (int i = 0; i < 5; i++) upd("t3_t", 32'h108, 1'b1);
        look("t3_l3", 32'h108);
        upd("t3_n1", 32'h108, 1'b0);
        look("t3_l2", 32'h108);
        upd("t3_n2", 32'h108, 1'b0);
        look("t3_l1", 32'h108);

        // 4: aliasing on index 0, untouched entry stays not-taken
        upd("t4_u", 32'h100, 1'b1);
        look("t4_alias", 32'h200);
        look("t4_other", 32'h1F0);

        // 5: same-cycle lookup and update, no bypass
        step("t5_same", 1'b1, 32'h10C, 1'b1, 32'h10C, 1'b1);
        look("t5_next", 32'h10C);

        // Saturate low at 0x110: no wrap to 3
        for (int i = 0; i < 3; i++) upd("sat_n", 32'h110, 1'b0);
        look("sat_l0", 32'h110);
        upd("sat_t1", 32'h110, 1'b1);
        look("sat_l1", 32'h110);
        upd("sat_t2", 32'h110, 1'b1);
        look("sat_l2", 32'h110);

        // 6: reset mid-sweep, then updates during INIT must be dropped
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst0_ready", bus.bht_ready, 1'b0);
        check("t6_rst0_pred", bus.pred_taken, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 30; i++) look("t6_sweep_a", 32'h104);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst1_ready", bus.bht_ready, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 64; i++) step("t6_sweep_b", 1'b1, 32'h100, 1'b1, 32'h100, 1'b1);
        look("t6_l100", 32'h100);
        look("t6_l104", 32'h104);
        look("t6_l10c", 32'h10C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
